// File: rtl/tt_um_serial_addsub.sv
// Bit-serial add/subtract tile: operands load byte-wide, then ripple LSB-first
// through a single full-adder cell and carry flop, one bit per enabled clock.
module tt_um_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [WIDTH-1:0]   acc_q, acc_d, result_q, result_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic load_a, load_b, start, sub;
    logic sum_bit, carry_nx;

    assign load_a = uio_in[0];
    assign load_b = uio_in[1];
    assign start  = uio_in[2];
    assign sub    = uio_in[3];

    assign sum_bit  = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    assign carry_nx = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (state_q == RUN) begin
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            carry_d = carry_nx;
            acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'(WIDTH-1)) begin
                // carry_q here is the carry into the MSB, carry_nx the carry out of it
                result_d = acc_d;
                cout_d   = carry_nx;
                ovf_d    = carry_q ^ carry_nx;
                state_d  = DONE;
            end
        end else begin
            if (load_a) op_a_d = ui_in[WIDTH-1:0];
            if (load_b) op_b_d = ui_in[WIDTH-1:0];
            if (start && !load_a && !load_b) begin
                sh_a_d  = op_a_q;
                sh_b_d  = sub ? ~op_b_q : op_b_q;
                carry_d = sub;
                cnt_d   = 3'd0;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign uo_out  = 8'(result_q);
    assign uio_out = {ovf_q, cout_q, state_q == DONE, state_q == RUN, 4'b0000};
    assign uio_oe  = 8'hF0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in[7:4], ui_in};

endmodule
